// File: rtl/std_div_pkg.sv
// Shared types and sizing helpers for the iterative divide/modulo primitive.
package std_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} div_state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  // Counter wide enough to hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/std_divmod_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, counter flags the last step.
module std_divmod_core
  import std_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dvs_in,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   trial;

  // The partial remainder is always below the divisor after a step, so only
  // the WIDTH+1-bit trial value needs the extra bit.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    trial = {rem_q, dvd_q[WIDTH-1]};
    if (load) begin
      dvd_d = dvd_in;
      dvs_d = dvs_in;
      quo_d = '0;
      rem_d = '0;
      cnt_d = '0;
    end else if (step) begin
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/std_divmod_pipe_ext.sv
// Multi-cycle go/done divider returning quotient and remainder, with signed,
// floored-remainder and divide-by-zero handling around an unsigned core.
module std_divmod_pipe_ext
  import std_div_pkg::*;
#(
  parameter int unsigned WIDTH   = DIV_WIDTH_DEFAULT,
  parameter bit          SIGNED  = 1'b0,
  parameter bit          FLOORED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             done
);

  div_state_t state_q, state_d;

  logic             start, step, commit, done_d, done_q;
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic             sgn_l_q, sgn_l_d, sgn_r_q, sgn_r_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             neg_l, neg_r;
  logic [WIDTH-1:0] mag_l, mag_r;
  logic [WIDTH-1:0] core_quo, core_rem, fix_q, fix_r;
  logic             core_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = (left == '0 || right == '0) ? FIN : RUN;
      RUN:     if (!go) state_d = IDLE; else if (core_last) state_d = FIN;
      FIN:     state_d = go ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start  = (state_q == IDLE) && go;
    step   = (state_q == RUN)  && go;
    commit = (state_q == FIN)  && go;
    done_d = (state_q == DONE);
  end

  // MIN negates to itself, which is exactly 2^(WIDTH-1) when read as unsigned.
  always_comb begin
    neg_l   = SIGNED && left[WIDTH-1];
    neg_r   = SIGNED && right[WIDTH-1];
    mag_l   = neg_l ? -left  : left;
    mag_r   = neg_r ? -right : right;
    left_d  = start ? left  : left_q;
    right_d = start ? right : right_q;
    sgn_l_d = start ? neg_l : sgn_l_q;
    sgn_r_d = start ? neg_r : sgn_r_q;
  end

  std_divmod_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (reset),
    .load   (start),
    .step   (step),
    .dvd_in (mag_l),
    .dvs_in (mag_r),
    .quo    (core_quo),
    .rem    (core_rem),
    .last   (core_last)
  );

  always_comb begin
    fix_q = core_quo;
    fix_r = core_rem;
    if (SIGNED) begin
      if (sgn_l_q != sgn_r_q) fix_q = -core_quo;
      if (sgn_l_q) fix_r = -core_rem;
      if (FLOORED && fix_r != '0 && fix_r[WIDTH-1] != sgn_r_q) begin
        fix_r = fix_r + right_q;
        fix_q = fix_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (commit) begin
      if (right_q == '0) begin
        quot_d = '1;
        rem_d  = left_q;
        dbz_d  = 1'b1;
      end else begin
        quot_d = fix_q;
        rem_d  = fix_r;
        dbz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      sgn_l_q <= 1'b0;
      sgn_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      left_q  <= left_d;
      right_q <= right_d;
      sgn_l_q <= sgn_l_d;
      sgn_r_q <= sgn_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign div_by_zero   = dbz_q;
  assign done          = done_q;

endmodule

// File: tb/tb_std_divmod_pipe_ext.sv
// Scoreboard bench over four configurations: unsigned 8/32-bit, signed truncated and floored 8-bit.
module tb_std_divmod_pipe_ext;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [31:0] left_v = '0;
  logic [31:0] right_v = '0;
  int unsigned sel = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  logic [3:0]  go_v, dbz_v, done_v;
  logic [7:0]  q0, r0, q2, r2, q3, r3;
  logic [31:0] q1, r1;

  assign go_v[0] = go && (sel == 0);
  assign go_v[1] = go && (sel == 1);
  assign go_v[2] = go && (sel == 2);
  assign go_v[3] = go && (sel == 3);

  std_divmod_pipe_ext #(.WIDTH(8), .SIGNED(1'b0), .FLOORED(1'b0)) u_u8 (
    .clk(clk), .reset(reset), .go(go_v[0]), .left(left_v[7:0]), .right(right_v[7:0]),
    .out_quotient(q0), .out_remainder(r0), .div_by_zero(dbz_v[0]), .done(done_v[0]));

  std_divmod_pipe_ext #(.WIDTH(32), .SIGNED(1'b0), .FLOORED(1'b0)) u_u32 (
    .clk(clk), .reset(reset), .go(go_v[1]), .left(left_v), .right(right_v),
    .out_quotient(q1), .out_remainder(r1), .div_by_zero(dbz_v[1]), .done(done_v[1]));

  std_divmod_pipe_ext #(.WIDTH(8), .SIGNED(1'b1), .FLOORED(1'b0)) u_s8 (
    .clk(clk), .reset(reset), .go(go_v[2]), .left(left_v[7:0]), .right(right_v[7:0]),
    .out_quotient(q2), .out_remainder(r2), .div_by_zero(dbz_v[2]), .done(done_v[2]));

  std_divmod_pipe_ext #(.WIDTH(8), .SIGNED(1'b1), .FLOORED(1'b1)) u_f8 (
    .clk(clk), .reset(reset), .go(go_v[3]), .left(left_v[7:0]), .right(right_v[7:0]),
    .out_quotient(q3), .out_remainder(r3), .div_by_zero(dbz_v[3]), .done(done_v[3]));

  logic [31:0] obs_q, obs_r;
  logic        obs_dbz, obs_done;

  always_comb begin
    obs_q = '0; obs_r = '0; obs_dbz = 1'b0; obs_done = 1'b0;
    case (sel)
      0:       begin obs_q = {24'd0, q0}; obs_r = {24'd0, r0}; obs_dbz = dbz_v[0]; obs_done = done_v[0]; end
      1:       begin obs_q = q1;          obs_r = r1;          obs_dbz = dbz_v[1]; obs_done = done_v[1]; end
      2:       begin obs_q = {24'd0, q2}; obs_r = {24'd0, r2}; obs_dbz = dbz_v[2]; obs_done = done_v[2]; end
      default: begin obs_q = {24'd0, q3}; obs_r = {24'd0, r3}; obs_dbz = dbz_v[3]; obs_done = done_v[3]; end
    endcase
  end

  // Reference arithmetic in 64-bit integers; config 1 is 32-bit unsigned, 2/3 signed 8-bit.
  function automatic exp_t model(input int unsigned s, input logic [31:0] l_in, input logic [31:0] r_in);
    exp_t        e;
    logic [31:0] mask, l, r;
    longint      a, b, q, rm;
    int unsigned w;
    w    = (s == 1) ? 32 : 8;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    l    = l_in & mask;
    r    = r_in & mask;
    e.lat = (l == 0 || r == 0) ? 2 : w + 2;
    if (r == 0) begin
      e.q = mask; e.r = l; e.dbz = 1'b1;
      return e;
    end
    e.dbz = 1'b0;
    if (s >= 2) begin
      a = l[7] ? longint'(l) - 256 : longint'(l);
      b = r[7] ? longint'(r) - 256 : longint'(r);
      q  = a / b;
      rm = a - q * b;
      if (s == 3 && rm != 0 && ((rm < 0) != (b < 0))) begin
        rm = rm + b;
        q  = q - 1;
      end
    end else begin
      a  = longint'(l);
      b  = longint'(r);
      q  = a / b;
      rm = a % b;
    end
    e.q = 32'(q) & mask;
    e.r = 32'(rm) & mask;
    return e;
  endfunction

  task automatic run_op(input string name, input int unsigned s, input logic [31:0] l,
                        input logic [31:0] r, input bit keep_go);
    exp_t e;
    int   cyc;
    bit   seen;
    sel = s; left_v = l; right_v = r; go = 1'b1;
    sb.push_back(model(s, l, r));
    seen = 1'b0;
    cyc  = -1;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (obs_done) seen = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      $display("FAIL %s timeout: no done within %0d cycles, want latency %0d", name, cyc, e.lat);
      failures++;
      go = 1'b0;
      return;
    end
    if (cyc != int'(e.lat)) begin
      $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat); failures++;
    end
    checks++;
    if (obs_q !== e.q) begin
      $display("FAIL %s quotient: got %h want %h", name, obs_q, e.q); failures++;
    end
    checks++;
    if (obs_r !== e.r) begin
      $display("FAIL %s remainder: got %h want %h", name, obs_r, e.r); failures++;
    end
    checks++;
    if (obs_dbz !== e.dbz) begin
      $display("FAIL %s div_by_zero: got %b want %b", name, obs_dbz, e.dbz); failures++;
    end
    last_q = e.q;
    last_r = e.r;
    if (!keep_go) begin
      go = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs_done !== 1'b0) begin
        $display("FAIL %s done_pulse: got %b want 0", name, obs_done); failures++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    for (int unsigned i = 0; i < 4; i++) begin
      sel = i;
      #1;
      checks++;
      if (obs_q !== '0 || obs_r !== '0 || obs_dbz !== 1'b0 || obs_done !== 1'b0) begin
        $display("FAIL reset_state cfg%0d: got q=%h r=%h dbz=%b done=%b want all 0",
                 i, obs_q, obs_r, obs_dbz, obs_done);
        failures++;
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    run_op("u8_200_7", 0, 200, 7, 1'b0);
    run_op("u8_zero_left", 0, 0, 13, 1'b0);
    run_op("u8_255_255", 0, 255, 255, 1'b0);
    run_op("u8_255_1", 0, 255, 1, 1'b0);
    run_op("u8_3_200", 0, 3, 200, 1'b0);
    for (int i = 0; i < 3; i++) run_op("u8_rand", 0, $urandom_range(255), $urandom_range(255, 1), 1'b0);
    run_op("u32_max_1", 1, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("u32_min_3", 1, 32'h8000_0000, 3, 1'b0);
    run_op("u32_dbz", 1, 32'd12345678, 0, 1'b0);
    for (int i = 0; i < 2; i++) run_op("u32_rand", 1, $urandom, $urandom_range(65535, 1), 1'b0);
  endtask

  task automatic test_signed();
    for (int unsigned s = 2; s < 4; s++) begin
      run_op("s8_m7_2", s, 32'hF9, 2, 1'b0);
      run_op("s8_7_m2", s, 7, 32'hFE, 1'b0);
      run_op("s8_min_m1", s, 32'h80, 32'hFF, 1'b0);
      run_op("s8_min_3", s, 32'h80, 3, 1'b0);
      run_op("s8_m9_m4", s, 32'hF7, 32'hFC, 1'b0);
      run_op("s8_zero_left", s, 0, 32'hFD, 1'b0);
      run_op("s8_dbz", s, 5, 0, 1'b0);
      run_op("s8_dbz_neg", s, 32'h83, 0, 1'b0);
      for (int i = 0; i < 3; i++) run_op("s8_rand", s, $urandom_range(255), $urandom_range(255, 1), 1'b0);
    end
  endtask

  task automatic test_abort_reset();
    int unsigned dones;
    sel = 0; left_v = 200; right_v = 7; go = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs_q !== '0 || obs_r !== '0 || obs_dbz !== 1'b0 || obs_done !== 1'b0) begin
      $display("FAIL abort_reset_clear: got q=%h r=%h dbz=%b done=%b want all 0",
               obs_q, obs_r, obs_dbz, obs_done);
      failures++;
    end
    go = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    dones = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (obs_done) dones++;
    end
    checks++;
    if (dones != 0) begin
      $display("FAIL abort_reset_no_done: got %0d done pulses want 0", dones); failures++;
    end
    run_op("u8_restart_100_9", 0, 100, 9, 1'b0);
  endtask

  task automatic test_abort_go();
    int unsigned dones;
    run_op("u8_pre_abort", 0, 77, 5, 1'b0);
    left_v = 200; right_v = 3; go = 1'b1;
    repeat (4) @(posedge clk);
    #1 go = 1'b0;
    dones = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (obs_done) dones++;
    end
    checks++;
    if (dones != 0) begin
      $display("FAIL abort_go_no_done: got %0d done pulses want 0", dones); failures++;
    end
    checks++;
    if (obs_q !== last_q || obs_r !== last_r) begin
      $display("FAIL abort_go_hold: got q=%h r=%h want q=%h r=%h", obs_q, obs_r, last_q, last_r);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_50_5", 0, 50, 5, 1'b1);
    run_op("b2b_9_4", 0, 9, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_abort_reset();
    test_abort_go();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
